// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ioctl-to-SDRAM download packer.
// Entry layout, FSM states and the PROM bank marker.
package jtframe_dwnld_pkg;

   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } dwnld_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      GAP
   } state_t;

   // Bit 2 set marks PROM space; bits 1:0 carry the SDRAM bank
   localparam logic [2:0] BANK_PROM = 3'b100;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO holding captured ioctl bytes.
// Push while full is ignored unless a pop frees the slot.
module jtframe_dwnld_fifo #(
   parameter int DW = 33,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          wr_en;
   logic          rd_en;

   assign empty = (cnt == '0);
   assign full  = cnt[AW];
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Packs ioctl bytes into masked 16-bit SDRAM programming writes.
// PROM-space bytes produce a prom_we strobe instead of a write.
module jtframe_dwnld_pack
   import jtframe_dwnld_pkg::*;
#(
   parameter logic [24:0] BA1_START  = 25'h08_0000,
   parameter logic [24:0] BA2_START  = 25'h10_0000,
   parameter logic [24:0] BA3_START  = 25'h18_0000,
   parameter logic [24:0] PROM_START = 25'h20_0000,
   parameter bit          SWAB       = 1'b0,
   parameter int          FIFO_AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_ba,
   output logic        prog_we,
   input  logic        prog_rdy,
   output logic        prom_we,
   output logic        dwnld_busy,
   output logic        overflow
);

   localparam int DW = $bits(dwnld_entry_t);

   dwnld_entry_t  din;
   dwnld_entry_t  head;
   logic [DW-1:0] head_bits;
   logic          empty;
   logic          full;
   logic          pop;
   logic          dl_q;
   state_t        state_q;
   state_t        state_d;
   logic [2:0]    bank;
   logic [24:0]   base;
   logic [22:0]   off;
   logic [21:0]   waddr;
   logic          lane;

   assign din  = '{addr: ioctl_addr, data: ioctl_data};
   assign head = head_bits;

   jtframe_dwnld_fifo #(
      .DW (DW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ioctl_wr),
      .pop   (pop),
      .din   (din),
      .dout  (head_bits),
      .empty (empty),
      .full  (full)
   );

   always_comb begin
      bank = BANK_PROM;
      base = PROM_START;
      unique case (1'b1)
         head.addr < BA1_START: begin
            bank = 3'd0;
            base = '0;
         end
         head.addr >= BA1_START && head.addr < BA2_START: begin
            bank = 3'd1;
            base = BA1_START;
         end
         head.addr >= BA2_START && head.addr < BA3_START: begin
            bank = 3'd2;
            base = BA2_START;
         end
         head.addr >= BA3_START && head.addr < PROM_START: begin
            bank = 3'd3;
            base = BA3_START;
         end
         head.addr >= PROM_START: ;
         default: ;
      endcase
   end

   // SDRAM wants a word address, PROM loaders want the byte offset
   assign off   = 23'(head.addr - base);
   assign waddr = bank[2] ? off[21:0] : off[22:1];
   assign lane  = head.addr[0] ^ SWAB;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (prom_we || prog_rdy) state_d = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prog_addr  <= '0;
         prog_data  <= '0;
         prog_mask  <= 2'b11;
         prog_ba    <= '0;
         prog_we    <= 1'b0;
         prom_we    <= 1'b0;
         dwnld_busy <= 1'b0;
         overflow   <= 1'b0;
         dl_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         dl_q       <= downloading;
         dwnld_busy <= downloading | ~empty | (state_q != IDLE);
         prom_we    <= pop & bank[2];
         if (pop) begin
            prog_addr <= waddr;
            prog_data <= {2{head.data}};
            prog_mask <= lane ? 2'b01 : 2'b10;
            prog_ba   <= bank[1:0];
            prog_we   <= ~bank[2];
         end else if (state_q == WRITE && prog_rdy) begin
            prog_we <= 1'b0;
         end
         if (ioctl_wr && full && !pop)
            overflow <= 1'b1;
         else if (downloading && !dl_q)
            overflow <= 1'b0;
      end
   end

endmodule
